mmio_master: RTL and testbench

CPU-side initiator for the MMIO device bus. It accepts one load or store at a time from the memory stage and drives `mmio_read`/`mmio_write`, `mmio_addr` and `mmio_write_data` to the device aggregator. It holds the request until `mmio_done`, then returns aligned and extended load data. Misaligned accesses are rejected before any bus cycle; accesses that never complete (unmapped addresses) end in a bus timeout.

---
 rtl/mmio_pkg.sv | 46 ++++
 rtl/mmio_master_if.sv | 38 +++
 rtl/mmio_load_align.sv | 27 ++
 rtl/mmio_master.sv | 150 +++++++++++++++
 tb/tb_mmio_master.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/mmio_pkg.sv
// Shared encodings and request payload for the MMIO initiator.
package mmio_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ERR_OK       = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_TIMEOUT  = 2'd2,
        ERR_UNSUP    = 2'd3
    } err_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Request attributes kept for the lifetime of a transaction
    typedef struct packed {
        logic       write;
        size_e      size;
        logic       is_signed;
        logic [1:0] addr_lo;
    } req_ctl_t;

    // Pre-bus legality check; misalignment takes priority over unsupported
    function automatic err_e check_req(input logic write, input size_e size,
                                       input logic [1:0] addr_lo);
        if ((size == SZ_HALF && addr_lo[0]) || (size == SZ_WORD && addr_lo != 2'b00))
            return ERR_MISALIGN;
        else if (size == SZ_RSVD || (write && size != SZ_WORD))
            return ERR_UNSUP;
        else
            return ERR_OK;
    endfunction

endpackage

// File: rtl/mmio_master_if.sv
// Request/response handshake and device-bus signals of the MMIO initiator.
interface mmio_master_if;
    import mmio_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic [1:0]        resp_err;

    logic              mmio_read;
    logic              mmio_write;
    logic [ADDR_W-1:0] mmio_addr;
    logic [DATA_W-1:0] mmio_write_data;
    logic              mmio_done;
    logic [DATA_W-1:0] mmio_read_data;

    modport master (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  mmio_done, mmio_read_data,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mmio_read, mmio_write, mmio_addr, mmio_write_data
    );

    modport slave (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output mmio_done, mmio_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mmio_read, mmio_write, mmio_addr, mmio_write_data
    );

endinterface

// File: rtl/mmio_load_align.sv
// Load lane selection and zero/sign extension of a device read word.
module mmio_load_align
    import mmio_pkg::*;
(
    input  logic [1:0]        addr_lo,
    input  size_e             size,
    input  logic              is_signed,
    input  logic [DATA_W-1:0] word,
    output logic [DATA_W-1:0] data_c
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Pick the addressed lane, then extend it to a full word
    always_comb begin
        byte_v = 8'(word >> {addr_lo, 3'b000});
        half_v = 16'(word >> {addr_lo[1], 4'b0000});
        data_c = word;
        case (size)
            SZ_BYTE: data_c = {{24{is_signed & byte_v[7]}}, byte_v};
            SZ_HALF: data_c = {{16{is_signed & half_v[15]}}, half_v};
            default: data_c = word;
        endcase
    end

endmodule

// File: rtl/mmio_master.sv
// Single-outstanding MMIO initiator: checks, strobes, waits for done or timeout.
module mmio_master
    import mmio_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic          sys_clk,
    input  logic          rst_n,
    mmio_master_if.master bus
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    req_ctl_t          ctl_q, ctl_d;

    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    err_e              resp_err_q, resp_err_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    err_e              chk_err_c;
    logic [DATA_W-1:0] load_data_c;

    mmio_load_align u_align (
        .addr_lo   (ctl_q.addr_lo),
        .size      (ctl_q.size),
        .is_signed (ctl_q.is_signed),
        .word      (bus.mmio_read_data),
        .data_c    (load_data_c)
    );

    // State, counter, request latches and registered outputs
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            ctl_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= ERR_OK;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ctl_q        <= ctl_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ctl_d        = ctl_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        chk_err_c    = check_req(bus.req_write, size_e'(bus.req_size), bus.req_addr[1:0]);

        case (state_q)
            ST_IDLE: begin
                req_ready_d = 1'b1;
                if (bus.req_valid) begin
                    ctl_d.write     = bus.req_write;
                    ctl_d.size      = size_e'(bus.req_size);
                    ctl_d.is_signed = bus.req_signed;
                    ctl_d.addr_lo   = bus.req_addr[1:0];
                    addr_d          = {bus.req_addr[ADDR_W-1:2], 2'b00};
                    wdata_d         = bus.req_write ? bus.req_wdata : '0;
                    cnt_d           = '0;
                    req_ready_d     = 1'b0;
                    if (chk_err_c != ERR_OK) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = chk_err_c;
                        resp_rdata_d = '0;
                    end else begin
                        state_d = ST_BUSY;
                        rd_d    = !bus.req_write;
                        wr_d    = bus.req_write;
                    end
                end
            end
            ST_BUSY: begin
                if (bus.mmio_done) begin
                    state_d      = ST_RESP;
                    cnt_d        = '0;
                    rd_d         = 1'b0;
                    wr_d         = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = ERR_OK;
                    resp_rdata_d = ctl_q.write ? '0 : load_data_c;
                end else if (cnt_q == CNT_LAST) begin
                    state_d      = ST_RESP;
                    cnt_d        = '0;
                    rd_d         = 1'b0;
                    wr_d         = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = ERR_TIMEOUT;
                    resp_rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
                rd_d        = 1'b0;
                wr_d        = 1'b0;
            end
        endcase
    end

    assign bus.req_ready       = req_ready_q;
    assign bus.resp_valid      = resp_valid_q;
    assign bus.resp_rdata      = resp_rdata_q;
    assign bus.resp_err        = resp_err_q;
    assign bus.mmio_read       = rd_q;
    assign bus.mmio_write      = wr_q;
    assign bus.mmio_addr       = addr_q;
    assign bus.mmio_write_data = wdata_q;

endmodule

// File: tb/tb_mmio_master.sv
// Scoreboard bench for mmio_master with a short timeout.
module tb_mmio_master;
    import mmio_pkg::*;

    localparam int unsigned TMO = 8;
    localparam logic [31:0] JUNK = 32'hA5A5_A5A5;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  err;
        int          strobes;
        int          lat;
    } exp_t;

    logic sys_clk = 1'b0;
    logic rst_n   = 1'b1;

    mmio_master_if bus();

    mmio_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          tmo_req = 0;
    int          tmo_seen = 0;

    // Monitor state
    int          cyc = 0;
    int          acc_cyc = 0;
    int          strobe_n = 0;
    logic [31:0] exp_addr = '0;
    logic [31:0] exp_wdata = '0;
    logic [1:0]  exp_dir = '0;
    exp_t        mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: strobe tracking, reset behaviour, response scoreboard
    always @(negedge sys_clk) begin
        cyc++;
        if (tmo_req != tmo_seen) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_bound: got %0d expired waits, expected 0", tmo_req - tmo_seen);
            tmo_seen = tmo_req;
        end
        if (!rst_n) begin
            check("rst_req_ready", 32'(bus.req_ready), 32'd1);
            check("rst_strobes", 32'({bus.mmio_write, bus.mmio_read}), 32'd0);
            check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
            check("rst_mmio_addr", bus.mmio_addr, 32'd0);
            check("rst_resp_rdata", bus.resp_rdata, 32'd0);
            strobe_n = 0;
        end else begin
            if (bus.mmio_read || bus.mmio_write) begin
                strobe_n++;
                check("strobe_dir", 32'({bus.mmio_write, bus.mmio_read}), 32'(exp_dir));
                check("strobe_addr", bus.mmio_addr, exp_addr);
                if (exp_dir == 2'b10)
                    check("strobe_wdata", bus.mmio_write_data, exp_wdata);
            end
            if (bus.resp_valid) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_resp: got resp_valid=1, expected 0");
                end else begin
                    mon_e = sb.pop_front();
                    check("resp_rdata", bus.resp_rdata, mon_e.rdata);
                    check("resp_err", 32'(bus.resp_err), 32'(mon_e.err));
                    check("strobe_cycles", 32'(strobe_n), 32'(mon_e.strobes));
                    check("latency", 32'(cyc - acc_cyc), 32'(mon_e.lat));
                end
                strobe_n = 0;
            end
            if (bus.req_valid && bus.req_ready) begin
                acc_cyc   = cyc;
                exp_addr  = {bus.req_addr[31:2], 2'b00};
                exp_wdata = bus.req_wdata;
                exp_dir   = bus.req_write ? 2'b10 : 2'b01;
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!bus.req_ready && n < 50) begin
            @(posedge sys_clk);
            #1;
            n++;
        end
        if (!bus.req_ready) tmo_req++;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge sys_clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            tmo_req++;
            sb.delete();
        end
    endtask

    // Offer one request, play the device (done in BUSY cycle done_at, 0 = never)
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int done_at, input logic [31:0] dev_data,
                          input logic [31:0] e_rdata, input logic [1:0] e_err,
                          input int e_strobes, input int e_lat, input bit expect_resp);
        exp_t e;
        wait_ready();
        bus.req_write  = wr;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_valid  = 1'b1;
        if (expect_resp) begin
            e.rdata   = e_rdata;
            e.err     = e_err;
            e.strobes = e_strobes;
            e.lat     = e_lat;
            sb.push_back(e);
        end
        @(posedge sys_clk);
        #1;
        bus.req_valid = 1'b0;
        if (done_at > 0) begin
            for (int i = 1; i < done_at; i++) begin
                @(posedge sys_clk);
                #1;
            end
            bus.mmio_done      = 1'b1;
            bus.mmio_read_data = dev_data;
            @(posedge sys_clk);
            #1;
            bus.mmio_done      = 1'b0;
            bus.mmio_read_data = JUNK;
        end
        if (expect_resp) wait_drain();
    endtask

    // Directed stimulus
    initial begin
        bus.req_valid      = 1'b0;
        bus.req_write      = 1'b0;
        bus.req_size       = 2'd0;
        bus.req_signed     = 1'b0;
        bus.req_addr       = '0;
        bus.req_wdata      = '0;
        bus.mmio_done      = 1'b0;
        bus.mmio_read_data = JUNK;

        #1 rst_n = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1 rst_n = 1'b1;
        @(posedge sys_clk);
        #1;

        // wr, size, signed, addr, wdata, done_at, dev data, exp rdata, exp err, strobes, latency
        do_req(1'b0, 2'd2, 1'b0, 32'hFFFF_0004, 32'h0, 1, 32'h1234_5678, 32'h1234_5678, ERR_OK, 1, 2, 1'b1);
        do_req(1'b0, 2'd0, 1'b1, 32'hFFFF_0003, 32'h0, 1, 32'h80AA_BBCC, 32'hFFFF_FF80, ERR_OK, 1, 2, 1'b1);
        do_req(1'b0, 2'd1, 1'b0, 32'hFFFF_0002, 32'h0, 1, 32'h80AA_BBCC, 32'h0000_80AA, ERR_OK, 1, 2, 1'b1);
        do_req(1'b0, 2'd1, 1'b1, 32'hFFFF_0000, 32'h0, 1, 32'h80AA_BBCC, 32'hFFFF_BBCC, ERR_OK, 1, 2, 1'b1);
        do_req(1'b0, 2'd0, 1'b0, 32'hFFFF_0001, 32'h0, 1, 32'h80AA_BBCC, 32'h0000_00BB, ERR_OK, 1, 2, 1'b1);
        do_req(1'b0, 2'd0, 1'b1, 32'hFFFF_0001, 32'h0, 1, 32'h80AA_7BCC, 32'h0000_007B, ERR_OK, 1, 2, 1'b1);
        do_req(1'b1, 2'd2, 1'b0, 32'hFFFF_0080, 32'hDEAD_BEEF, 3, JUNK, 32'h0, ERR_OK, 3, 4, 1'b1);
        do_req(1'b0, 2'd2, 1'b0, 32'hFFFF_0400, 32'h0, 0, JUNK, 32'h0, ERR_TIMEOUT, 8, 9, 1'b1);
        do_req(1'b0, 2'd2, 1'b0, 32'hFFFF_0400, 32'h0, 8, 32'h1122_3344, 32'h1122_3344, ERR_OK, 8, 9, 1'b1);
        do_req(1'b0, 2'd1, 1'b0, 32'hFFFF_0001, 32'h0, 0, JUNK, 32'h0, ERR_MISALIGN, 0, 1, 1'b1);
        do_req(1'b1, 2'd0, 1'b0, 32'hFFFF_0010, 32'h0000_00AB, 0, JUNK, 32'h0, ERR_UNSUP, 0, 1, 1'b1);
        do_req(1'b0, 2'd3, 1'b0, 32'hFFFF_0000, 32'h0, 0, JUNK, 32'h0, ERR_UNSUP, 0, 1, 1'b1);
        do_req(1'b0, 2'd2, 1'b0, 32'hFFFF_0006, 32'h0, 0, JUNK, 32'h0, ERR_MISALIGN, 0, 1, 1'b1);
        do_req(1'b0, 2'd1, 1'b1, 32'hFFFF_0002, 32'h0, 2, 32'h7FFF_0000, 32'h0000_7FFF, ERR_OK, 2, 3, 1'b1);

        // Abort a load mid-BUSY with reset; no response may follow
        do_req(1'b0, 2'd2, 1'b0, 32'hFFFF_0008, 32'h0, 0, JUNK, 32'h0, ERR_OK, 0, 0, 1'b0);
        repeat (3) @(posedge sys_clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1 rst_n = 1'b1;
        repeat (12) @(posedge sys_clk);
        #1;

        do_req(1'b0, 2'd2, 1'b0, 32'hFFFF_000C, 32'h0, 1, 32'hCAFE_F00D, 32'hCAFE_F00D, ERR_OK, 1, 2, 1'b1);

        repeat (3) @(negedge sys_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
